// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: length codes, FSM state codes,
// bus owner codes and the byte-count width.
package mem_ctrl_pkg;

  // mem_len encodings (2'b11 behaves as a word)
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Owner of the current access
  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Byte count / byte index width (holds 0..4)
  localparam int CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

  // Number of bytes moved for a data access of the given length code
  function automatic cnt_t len2cnt(input logic [1:0] len);
    case (len)
      LEN_BYTE: len2cnt = cnt_t'(1);
      LEN_HALF: len2cnt = cnt_t'(2);
      default:  len2cnt = cnt_t'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic between the fetch port and the data port.
// Build option MEM_CTRL_FAIR_ARB_EN: round-robin on collisions using the
// last-grant history bit; otherwise the data port always has priority.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic i_if_req,
  input  logic i_mem_req,
  input  logic i_last_if,   // 1 = previous grant went to the fetch port
  output logic o_gnt,
  output logic o_own
);

`ifdef MEM_CTRL_FAIR_ARB_EN
  // Collision goes to whichever port lost last time; lone requester wins
  always_comb begin
    o_gnt = i_if_req | i_mem_req;
    if (i_if_req && i_mem_req)
      o_own = i_last_if ? OWN_DATA : OWN_IF;
    else
      o_own = i_mem_req ? OWN_DATA : OWN_IF;
  end
`else
  // History is irrelevant with fixed priority
  logic w_unused_last;
  assign w_unused_last = i_last_if;

  // Fixed priority: data port beats fetch port
  always_comb begin
    o_gnt = i_if_req | i_mem_req;
    o_own = i_mem_req ? OWN_DATA : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller sharing one 8-bit RAM port between
// instruction fetch and data load/store. Multi-byte accesses are split into
// sequential byte cycles with 32-bit address wrap.
// Build option MEM_CTRL_FAIR_ARB_EN (evaluated inside mem_ctrl_arb).
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_done,
  output logic [31:0] o_if_data,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [1:0]  i_mem_len,
  input  logic [31:0] i_mem_wdata,
  output logic        o_mem_done,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_ram_a,
  output logic        o_ram_wr,
  output logic [7:0]  o_ram_dout,
  input  logic [7:0]  i_ram_din,
  output logic        o_busy
);

  logic [1:0]  r_state;
  logic        r_own;
  logic        r_we;
  cnt_t        r_cnt;      // bytes in this access
  cnt_t        r_k;        // byte index currently on ram_a (reaches r_cnt on loads)
  logic [31:0] r_wdata;
  logic [31:0] r_buf;      // load assembly buffer
  logic        r_last_if;
  logic        r_if_done, r_mem_done;
  logic [31:0] r_if_data, r_mem_rdata;
  logic [31:0] r_ram_a;
  logic        r_ram_wr;
  logic [7:0]  r_ram_dout;

  logic        w_gnt, w_own;
  logic [31:0] w_buf_nxt;
  logic [7:0]  w_wbyte_nxt;

  mem_ctrl_arb u_arb (
    .i_if_req  (i_if_req),
    .i_mem_req (i_mem_req),
    .i_last_if (r_last_if),
    .o_gnt     (w_gnt),
    .o_own     (w_own)
  );

  // ram_din holds the byte addressed one cycle earlier, i.e. byte r_k-1
  always_comb begin
    w_buf_nxt = r_buf;
    if (!r_we) begin
      case (r_k)
        cnt_t'(1): w_buf_nxt[7:0]   = i_ram_din;
        cnt_t'(2): w_buf_nxt[15:8]  = i_ram_din;
        cnt_t'(3): w_buf_nxt[23:16] = i_ram_din;
        cnt_t'(4): w_buf_nxt[31:24] = i_ram_din;
        default:   w_buf_nxt = r_buf;
      endcase
    end
  end

  // Store byte for the next byte cycle
  always_comb begin
    case (r_k)
      cnt_t'(0): w_wbyte_nxt = r_wdata[15:8];
      cnt_t'(1): w_wbyte_nxt = r_wdata[23:16];
      cnt_t'(2): w_wbyte_nxt = r_wdata[31:24];
      default:   w_wbyte_nxt = 8'h00;
    endcase
  end

  // Access FSM: accept in IDLE, stream bytes in RUN, pulse done in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_own       <= OWN_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_last_if   <= 1'b1;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_ram_a     <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_state   <= ST_RUN;
            r_own     <= w_own;
            r_k       <= '0;
            r_buf     <= '0;
            r_last_if <= (w_own == OWN_IF);
            if (w_own == OWN_DATA) begin
              r_we       <= i_mem_we;
              r_cnt      <= len2cnt(i_mem_len);
              r_wdata    <= i_mem_wdata;
              r_ram_a    <= i_mem_addr;
              r_ram_wr   <= i_mem_we;
              r_ram_dout <= i_mem_we ? i_mem_wdata[7:0] : 8'h00;
            end else begin
              r_we       <= 1'b0;
              r_cnt      <= cnt_t'(4);
              r_wdata    <= '0;
              r_ram_a    <= i_if_addr;
              r_ram_wr   <= 1'b0;
              r_ram_dout <= 8'h00;
            end
          end
        end
        ST_RUN: begin
          r_buf <= w_buf_nxt;
          if ((r_we && r_k == r_cnt - cnt_t'(1)) || (!r_we && r_k == r_cnt)) begin
            // last store byte issued, or last load byte now on ram_din
            r_state    <= ST_DONE;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'h00;
            if (r_own == OWN_IF) begin
              r_if_done <= 1'b1;
              r_if_data <= w_buf_nxt;
            end else begin
              r_mem_done <= 1'b1;
              if (!r_we) r_mem_rdata <= w_buf_nxt;
            end
          end else if (r_k == r_cnt - cnt_t'(1)) begin
            // load: wait one cycle for the final byte, address held
            r_k <= r_k + cnt_t'(1);
          end else begin
            r_k     <= r_k + cnt_t'(1);
            r_ram_a <= r_ram_a + 32'd1;
            if (r_we) r_ram_dout <= w_wbyte_nxt;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_if_done   = r_if_done;
  assign o_if_data   = r_if_data;
  assign o_mem_done  = r_mem_done;
  assign o_mem_rdata = r_mem_rdata;
  assign o_ram_a     = r_ram_a;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_dout  = r_ram_dout;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of directed accesses, hand-written
// collision / reset / held-request sequences, then random accesses checked
// against a byte-addressed reference memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int dual_cnt = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_data(if_data),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_len(mem_len),
    .i_mem_wdata(mem_wdata), .o_mem_done(mem_done), .o_mem_rdata(mem_rdata),
    .o_ram_a(ram_a), .o_ram_wr(ram_wr), .o_ram_dout(ram_dout), .i_ram_din(ram_din),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- external RAM (the world) ----------------
  logic [7:0] ram [logic [31:0]];
  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'hA5;
  endfunction

  always @(posedge clk) ram_din <= ram.exists(ram_a) ? ram[ram_a] : dflt(ram_a);
  always @(negedge clk) if (ram_wr) ram[ram_a] = ram_dout;

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_mem [logic [31:0]];
  function automatic int nbytes(input bit is_if, input logic [1:0] len);
    if (is_if) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction
  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ai = a + i;
      v = v | ({24'd0, ref_mem.exists(ai) ? ref_mem[ai] : dflt(ai)} << (8 * i));
    end
    return v;
  endfunction
  task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
  endtask
  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  always @(negedge clk) if (if_done && mem_done) dual_cnt++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- single access driver ----------------
  logic [31:0] tr_a    [32];
  logic        tr_wr   [32];
  logic [7:0]  tr_dout [32];

  task automatic run_access(input bit is_if, input bit we, input logic [31:0] addr,
                            input logic [1:0] len, input logic [31:0] wdata,
                            output logic [31:0] data, output int lat);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_wr", {31'd0, ram_wr}, 32'd0);
    chk("idle_dout", {24'd0, ram_dout}, 32'd0);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wdata;
    end
    lat = -1;
    data = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tr_a[c] = ram_a; tr_wr[c] = ram_wr; tr_dout[c] = ram_dout;
      if (if_done || mem_done) begin
        chk("done_owner", {30'd0, if_done, mem_done}, is_if ? 32'd2 : 32'd1);
        data = is_if ? if_data : mem_rdata;
        lat = c;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    if (lat < 0) chk("timeout", 32'd1, 32'd0);
  endtask

  // Address / write-strobe / write-byte sequence and latency from the rules
  task automatic check_access(input bit is_if, input bit we, input logic [31:0] addr,
                              input logic [1:0] len, input logic [31:0] wdata, input int lat);
    int n = nbytes(is_if, len);
    int el = we ? n + 1 : n + 2;
    chk("latency", lat, el);
    if (lat != el) return;
    for (int k = 0; k < n; k++) begin
      chk("ram_a_seq", tr_a[k+1], addr + k);
      chk("ram_wr_seq", {31'd0, tr_wr[k+1]}, {31'd0, we});
      if (we) chk("ram_dout_seq", {24'd0, tr_dout[k+1]}, {24'd0, wdata[8*k +: 8]});
    end
    if (we) chk("wr_low_done", {31'd0, tr_wr[lat]}, 32'd0);
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] d;
    int lat, ci, cm, ndone, first, second;

    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, e;
    int lat, ci, cm, ndone, first, second, wd;

    vt[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'b10, 32'h0, 32'h0010_0513, 6};
    vt[1] = '{1'b0, 1'b1, 32'h0000_2002, 2'b10, 32'hDEAD_BEEF, 32'h0, 5};
    vt[2] = '{1'b0, 1'b0, 32'h0000_2002, 2'b10, 32'h0, 32'hDEAD_BEEF, 6};
    vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00, 32'h0, 32'h0000_0080, 3};
    vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0, 32'h0000_7F80, 4};
    vt[5] = '{1'b0, 1'b0, 32'h0000_2003, 2'b01, 32'h0, 32'h0000_ADBE, 4};
    vt[6] = '{1'b0, 1'b1, 32'h0000_2100, 2'b00, 32'hAABB_CC5A, 32'h0, 2};
    vt[7] = '{1'b0, 1'b0, 32'h0000_2100, 2'b11, 32'h0, 32'hA6A7_A45A, 6};

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    preload(32'hFFFF_FFFF, 8'h80); preload(32'h0, 8'h7F);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_access(vt[i].is_if, vt[i].we, vt[i].addr, vt[i].len, vt[i].wdata, d, lat);
      chk("vec_lat", lat, vt[i].exp_lat);
      if (!vt[i].we) chk("vec_data", d, vt[i].exp_data);
      else model_write(vt[i].addr, nbytes(1'b0, vt[i].len), vt[i].wdata);
      check_access(vt[i].is_if, vt[i].we, vt[i].addr, vt[i].len, vt[i].wdata, lat);
    end

    // Collision right after a data grant
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2002; mem_len = 2'b10;
    ci = 0; cm = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if_done && ci == 0) begin
        ci = c; chk("coll_if_data", if_data, 32'h0010_0513); if_req = 1'b0;
      end
      if (mem_done && cm == 0) begin
        cm = c; chk("coll_mem_data", mem_rdata, 32'hDEAD_BEEF); mem_req = 1'b0;
      end
      if (ci != 0 && cm != 0) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
`ifdef MEM_CTRL_FAIR_ARB_EN
    chk("coll_if_cycle", ci, 6);
    chk("coll_mem_cycle", cm, 13);
`else
    chk("coll_mem_cycle", cm, 6);
    chk("coll_if_cycle", ci, 13);
`endif

    // Reset during the third byte of a word store
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_len = 2'b10; mem_wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("mid_ram_a", ram_a, 32'h3002);
    chk("mid_ram_wr", {31'd0, ram_wr}, 32'd1);
    chk("mid_ram_dout", {24'd0, ram_dout}, 32'h22);
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    run_access(1'b1, 1'b0, 32'h100, 2'b10, 32'h0, d, lat);
    chk("post_rst_if_data", d, 32'h0010_0513);
    check_access(1'b1, 1'b0, 32'h100, 2'b10, 32'h0, lat);

    // Held request through DONE
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0010; mem_len = 2'b00;
    e = model_read(32'h8000_0010, 1);
    ndone = 0; first = 0; second = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_done) begin
        ndone++;
        if (first == 0) first = c; else if (second == 0) second = c;
        chk("held_data", mem_rdata, e);
      end
      if (c == 4) chk("held_idle_busy", {31'd0, busy}, 32'd0);
      if (c == 7) mem_req = 1'b0;
    end
    chk("held_ndone", ndone, 2);
    chk("held_first", first, 3);
    chk("held_second", second, 7);

    // Random accesses against the reference memory
    for (int i = 0; i < 60; i++) begin
      bit is_if, we;
      logic [31:0] a, wdat;
      logic [1:0] len;
      is_if = ($urandom_range(0, 3) == 0);
      we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      len   = is_if ? 2'b10 : 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : 32'h8000_0000 | 32'($urandom_range(0, 63));
      wdat  = $urandom;
      wd    = nbytes(is_if, len);
      e     = model_read(a, wd);
      run_access(is_if, we, a, len, wdat, d, lat);
      if (we) model_write(a, wd, wdat);
      else chk("rnd_data", d, e);
      check_access(is_if, we, a, len, wdat, lat);
    end

    chk("one_done_max", dual_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req  in  1  instruction-fetch request, level, held until if_done.
REQ-004 if_addr  in  32  fetch byte address.
REQ-005 if_done  out  1  one-cycle pulse, fetch complete.
REQ-006 if_data  out  32  fetched word, valid while if_done=1.
REQ-007 mem_req  in  1  data-access request, level, held until mem_done.
REQ-008 mem_we  in  1  1=store, 0=load.
REQ-009 mem_addr  in  32  data byte address.
REQ-010 mem_len  in  2  00=byte, 01=half, 10=word, 11=word.
REQ-011 mem_wdata  in  32  store data, little-endian, low bytes used for byte/half.
REQ-012 mem_done  out  1  one-cycle pulse, data access complete.
REQ-013 mem_rdata  out  32  load data, zero-extended, valid while mem_done=1.
REQ-014 ram_a  out  32  RAM byte address, registered.
REQ-015 ram_wr  out  1  RAM write enable, registered.
REQ-016 ram_dout  out  8  RAM write byte, registered.
REQ-017 ram_din  in  8  RAM read byte, valid the cycle after ram_a is driven.
REQ-018 busy  out  1  high whenever state != IDLE; feeds pipeline stall control.

Function
REQ-019 States IDLE, RUN, DONE; RUN carries owner (IF/DATA), byte count N (1, 2 or 4), byte index k.
REQ-020 IDLE: if any request is high at the edge, grant one, latch address, length, we and wdata, go to RUN with k=0.
REQ-021 Arbitration default: mem_req beats if_req; grant is never changed during RUN.
REQ-022 IF access always N=4, load; DATA N from mem_len.
REQ-023 RUN cycle k: ram_a = latched addr + k (mod 2^32); store drives ram_wr=1 and ram_dout = wdata byte k; load drives ram_wr=0.
REQ-024 Load: byte k sampled from ram_din in cycle k+1 after issue; placed in result bits [8k+7:8k]; unused upper bytes are 0.
REQ-025 Load latency: done pulse N+2 cycles after accepting edge (word = 6, byte = 3).
REQ-026 Store latency: done pulse N+1 cycles after accepting edge (word = 5, byte = 2); ram_wr low in the done cycle.
REQ-027 DONE lasts exactly one cycle: owner's done=1 and data valid; other done=0; requests are ignored; then IDLE.
REQ-028 At most one done output is high in any cycle.
REQ-029 Misaligned addresses are legal; bytes are accessed sequentially with wrap at 0xFFFFFFFF -> 0x00000000.
REQ-030 Request dropped mid-RUN: the access still completes and done still pulses.
REQ-031 IDLE outputs: ram_wr=0, ram_a holds last value, ram_dout=0, done=0, busy=0.

Reset
REQ-032 rst=1 at an edge: state IDLE, ram_a=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, busy=0, arbitration history = "last grant IF".
REQ-033 Reset mid-RUN aborts the access: no done pulse, and ram_wr=0 from the following cycle.

Configuration
REQ-034 Macro MEM_CTRL_FAIR_ARB_EN.
REQ-035 Defined: if both requests are high in IDLE, grant the requester that did not win the previous grant (round-robin); a single requester always wins.
REQ-036 Undefined: fixed priority per REQ-021; history register absent.

Structure
REQ-037 Shared package holds the mem_len encodings (LEN_BYTE/LEN_HALF/LEN_WORD), the state encoding, the owner encoding and the byte-count width.
REQ-038 One sub-module mem_ctrl_arb: combinational grant from if_req, mem_req and the history bit; MEM_CTRL_FAIR_ARB_EN is evaluated only there.
REQ-039 Total RTL 120-400 lines; no RAM model inside the block.

Verification
REQ-040 Fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 on consecutive cycles; if_done after 6 cycles; if_data=0x00100513.
REQ-041 Store word: mem_we=1, len=10, addr=0x2002, wdata=0xDEADBEEF -> ram_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x2002..0x2005; mem_done after 5 cycles.
REQ-042 Collision: if_req and mem_req rise together -> DATA served first and IF starts the cycle after DATA's DONE; with MEM_CTRL_FAIR_ARB_EN defined and previous grant DATA -> IF served first.
REQ-043 Byte load: len=00, addr=0xFFFFFFFF, ram_din=0x80 -> mem_rdata=0x00000080 after 3 cycles; half load at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000.
REQ-044 Reset during 3rd byte of a word store -> ram_wr=0 the next cycle, no mem_done, busy=0, new if_req accepted normally.
REQ-045 Held request: mem_req kept high through DONE -> exactly one mem_done pulse, re-accepted only at the edge after DONE.
